// File: rtl/ws2812_enc.sv
// WS2812 single-wire NRZ bit encoder with a one-bit hold register.
// Define WS2812_OUT_INV_EN to drive the line inverted (idle high).
module ws2812_enc #(
  parameter logic [15:0] T0H_CNT   = 16'd70,
  parameter logic [15:0] T1H_CNT   = 16'd140,
  parameter logic [15:0] BIT_CNT   = 16'd250,
  parameter logic [15:0] DONE_LEAD = 16'd8
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic bit_rdy_in,
  input  logic bit_data_in,
  output logic bit_done_out,
  output logic ws2812_data_out,
  output logic busy_out,
  output logic ovf_out
);

  typedef enum logic [1:0] {
    IDLE,
    HIGH,
    LOW
  } state_t;

  localparam logic [15:0] LAST    = BIT_CNT - 16'd1;
  localparam logic [15:0] DONE_AT = BIT_CNT - 16'd1 - DONE_LEAD;

`ifdef WS2812_OUT_INV_EN
  localparam logic LINE_IDLE = 1'b1;
`else
  localparam logic LINE_IDLE = 1'b0;
`endif

  state_t      state_q;
  state_t      state_d;
  logic [15:0] cnt_q;
  logic [15:0] cnt_d;
  logic [15:0] high_last;
  logic        cur_q;
  logic        cur_d;
  logic        hold_full_q;
  logic        hold_full_d;
  logic        hold_bit_q;
  logic        hold_bit_d;
  logic        ovf_d;
  logic        done_d;
  logic        busy_d;
  logic        line_d;
  logic        period_end;

  assign high_last  = (cur_q ? T1H_CNT : T0H_CNT) - 16'd1;
  assign period_end = (state_q == LOW) && (cnt_q == LAST);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    cur_d       = cur_q;
    hold_full_d = hold_full_q;
    hold_bit_d  = hold_bit_q;
    ovf_d       = ovf_out;
    done_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bit_rdy_in) begin
          state_d = HIGH;
          cnt_d   = '0;
          cur_d   = bit_data_in;
        end
      end
      HIGH: begin
        cnt_d = cnt_q + 16'd1;
        if (cnt_q == high_last) state_d = LOW;
      end
      LOW: begin
        cnt_d  = cnt_q + 16'd1;
        done_d = (cnt_q == DONE_AT);
      end
      default: state_d = IDLE;
    endcase

    // Handover at period end takes priority over the hold/overflow path
    if (period_end) begin
      cnt_d = '0;
      if (hold_full_q) begin
        state_d     = HIGH;
        cur_d       = hold_bit_q;
        hold_full_d = bit_rdy_in;
        if (bit_rdy_in) hold_bit_d = bit_data_in;
      end else if (bit_rdy_in) begin
        state_d = HIGH;
        cur_d   = bit_data_in;
      end else begin
        state_d = IDLE;
      end
    end else if (state_q != IDLE && bit_rdy_in) begin
      if (!hold_full_q) begin
        hold_full_d = 1'b1;
        hold_bit_d  = bit_data_in;
      end else begin
        ovf_d = 1'b1;
      end
    end

    line_d = (state_d == HIGH) ^ LINE_IDLE;
    busy_d = (state_d != IDLE) | hold_full_d;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      cnt_q           <= '0;
      cur_q           <= 1'b0;
      hold_full_q     <= 1'b0;
      hold_bit_q      <= 1'b0;
      ovf_out         <= 1'b0;
      bit_done_out    <= 1'b0;
      busy_out        <= 1'b0;
      ws2812_data_out <= LINE_IDLE;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      cur_q           <= cur_d;
      hold_full_q     <= hold_full_d;
      hold_bit_q      <= hold_bit_d;
      ovf_out         <= ovf_d;
      bit_done_out    <= done_d;
      busy_out        <= busy_d;
      ws2812_data_out <= line_d;
    end
  end

endmodule

// File: tb/tb_ws2812_enc.sv
// Self-checking bench for ws2812_enc: vector table, directed sequences
// and random strobes checked cycle by cycle against a timeline model.
module tb_ws2812_enc;

  localparam int BIT_CNT = 250;
  localparam int T0H     = 70;
  localparam int T1H     = 140;
  localparam int LEAD    = 8;

`ifdef WS2812_OUT_INV_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic rdy = 1'b0;
  logic dat = 1'b0;
  logic done;
  logic line;
  logic busy;
  logic ovf;
  logic lv;

  assign lv = line ^ INV;

  always #5 clk = ~clk;

  ws2812_enc dut (
    .clk_in         (clk),
    .rst_in         (rst),
    .bit_rdy_in     (rdy),
    .bit_data_in    (dat),
    .bit_done_out   (done),
    .ws2812_data_out(line),
    .busy_out       (busy),
    .ovf_out        (ovf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  // Timeline model: each accepted bit owns a BIT_CNT-cycle window
  int cyc = 0;
  bit m_on = 0;
  bit m_act = 0;
  int m_st = 0;
  bit m_cb = 0;
  bit m_pq[$];
  bit m_ovf = 0;

  bit plv = 0;
  bit pbusy = 0;
  int rise_t = 0;
  int busy_fall = 0;
  int rises[$];
  int widths[$];
  int dones[$];

  always @(negedge clk) begin
    int k;
    bit eh;
    bit ed;
    bit eb;
    cyc++;
    if (m_on) begin
      k  = cyc - m_st;
      eh = m_act && (k < (m_cb ? T1H : T0H));
      ed = m_act && (k == BIT_CNT - LEAD);
      eb = m_act || (m_pq.size() != 0);
      chk("cycle", {lv, done, busy, ovf}, {eh, ed, eb, m_ovf});
    end
    if (lv && !plv) begin
      rises.push_back(cyc);
      rise_t = cyc;
    end
    if (!lv && plv) widths.push_back(cyc - rise_t);
    if (!busy && pbusy) busy_fall = cyc;
    if (done) dones.push_back(cyc);
    plv   = lv;
    pbusy = busy;
    if (rst) begin
      m_on  = 1;
      m_act = 0;
      m_pq.delete();
      m_ovf = 0;
    end else if (m_on) begin
      if (m_act && (cyc - m_st == BIT_CNT - 1)) begin
        if (m_pq.size() != 0) begin
          m_cb = m_pq.pop_front();
          m_st = cyc + 1;
          if (rdy) m_pq.push_back(dat);
        end else if (rdy) begin
          m_cb = dat;
          m_st = cyc + 1;
        end else begin
          m_act = 0;
        end
      end else if (!m_act) begin
        if (rdy) begin
          m_act = 1;
          m_cb  = dat;
          m_st  = cyc + 1;
        end
      end else if (rdy) begin
        if (m_pq.size() == 0) m_pq.push_back(dat);
        else m_ovf = 1;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(bit d);
    rdy = 1'b1;
    dat = d;
    tick();
    rdy = 1'b0;
  endtask

  task automatic clear_rec();
    rises.delete();
    widths.delete();
    dones.delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 3000) begin
      tick();
      n++;
    end
    chk("idle_timeout", busy, 0);
    tick();
  endtask

  task automatic wait_done();
    int n = 0;
    bit ok = 0;
    while (!ok && n < 400) begin
      @(negedge clk);
      ok = done;
      n++;
    end
    chk("done_timeout", ok, 1);
    tick();
    tick();
  endtask

  typedef struct {
    bit d;
    int hi;
    int lo;
    int dn;
  } vec_t;

  vec_t vecs[3];

  task automatic run_vec(vec_t v);
    clear_rec();
    tick();
    strobe(v.d);
    wait_idle();
    chk("vec_rises", rises.size(), 1);
    chk("vec_dones", dones.size(), 1);
    if (rises.size() >= 1 && widths.size() >= 1) begin
      chk("vec_high", widths[0], v.hi);
      chk("vec_low", busy_fall - (rises[0] + widths[0]), v.lo);
      chk("vec_period", busy_fall - rises[0], BIT_CNT);
    end
    if (rises.size() >= 1 && dones.size() >= 1)
      chk("vec_done_pos", dones[0] - rises[0], v.dn);
    chk("vec_idle_line", lv, 0);
  endtask

  initial begin
    logic [23:0] pat;

    vecs[0] = '{d: 1'b1, hi: 140, lo: 110, dn: 242};
    vecs[1] = '{d: 1'b0, hi: 70,  lo: 180, dn: 242};
    vecs[2] = '{d: 1'b1, hi: 140, lo: 110, dn: 242};

    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    chk("reset_state", {lv, done, busy, ovf}, 0);
    chk("reset_raw_line", line, INV);

    for (int i = 0; i < 3; i++) run_vec(vecs[i]);

    // 24 back-to-back bits, each answered 2 cycles after bit_done_out
    pat = 24'hA5C30F;
    clear_rec();
    strobe(pat[23]);
    for (int i = 22; i >= 0; i--) begin
      wait_done();
      strobe(pat[i]);
    end
    wait_idle();
    chk("b2b_rises", rises.size(), 24);
    chk("b2b_dones", dones.size(), 24);
    chk("b2b_ovf", ovf, 0);
    if (rises.size() == 24 && widths.size() == 24) begin
      for (int i = 0; i < 24; i++) begin
        chk("b2b_high", widths[i], pat[23-i] ? T1H : T0H);
        if (i > 0) chk("b2b_period", rises[i] - rises[i-1], BIT_CNT);
      end
    end

    // Overflow: two strobes during HIGH, second one dropped
    clear_rec();
    strobe(1'b1);
    repeat (10) tick();
    strobe(1'b0);
    repeat (5) tick();
    strobe(1'b1);
    chk("ovf_set", ovf, 1);
    wait_idle();
    chk("ovf_rises", rises.size(), 2);
    if (rises.size() == 2 && widths.size() == 2) begin
      chk("ovf_gap", rises[1] - rises[0], BIT_CNT);
      chk("ovf_w0", widths[0], T1H);
      chk("ovf_w1", widths[1], T0H);
    end
    repeat (20) tick();
    chk("ovf_sticky", ovf, 1);

    // Reset at cnt=50 with the hold register full
    rdy = 1'b1;
    dat = 1'b1;
    tick();
    dat = 1'b0;
    tick();
    rdy = 1'b0;
    repeat (49) tick();
    chk("pre_rst_line", lv, 1);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    clear_rec();
    chk("mid_rst_out", {lv, done, busy, ovf}, 0);
    repeat (300) tick();
    chk("mid_rst_nodone", dones.size(), 0);
    chk("mid_rst_norise", rises.size(), 0);
    run_vec(vecs[1]);

    // Random strobes, gaps and occasional resets against the model
    for (int n = 0; n < 60; n++) begin
      int gap;
      gap = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 20)
                                         : $urandom_range(100, 400);
      repeat (gap) tick();
      if ($urandom_range(0, 29) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      strobe(1'($urandom_range(0, 1)));
    end
    wait_idle();
    chk("rand_end_line", lv, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
